// File: rtl/decode_scoreboard_pkg.sv
// Shared defaults and helpers for the register-write scoreboard.
package decode_scoreboard_pkg;

  localparam int unsigned IN_W_DEF      = 5;
  localparam int unsigned CNT_W_DEF     = 2;
  localparam bit          ZERO_LOCK_DEF = 1'b1;

  function automatic int unsigned out_n(input int unsigned in_w);
    return 32'd1 << in_w;
  endfunction

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_ZERO
  } cnt_op_e;

endpackage

// File: rtl/decode_scoreboard_decoder_onehot.sv
// Binary index to one-hot vector; every output bit is driven.
module decoder_onehot
  import decode_scoreboard_pkg::*;
#(
  parameter int unsigned IN_W = IN_W_DEF
) (
  input  logic [IN_W-1:0]      idx,
  output logic [2**IN_W-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Per-register outstanding-write counters with set/clear/flush and busy lookup.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int unsigned IN_W      = IN_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter bit          ZERO_LOCK = ZERO_LOCK_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_valid,
  input  logic [IN_W-1:0]          set_idx,
  output logic                     set_ready,
  input  logic                     clr_valid,
  input  logic [IN_W-1:0]          clr_idx,
  input  logic                     flush,
  input  logic [IN_W-1:0]          rs_idx,
  input  logic [IN_W-1:0]          rt_idx,
  output logic                     rs_busy,
  output logic                     rt_busy,
  output logic [out_n(IN_W)-1:0]   busy_vec,
  output logic                     err_underflow
);

  localparam int unsigned OUT_N = out_n(IN_W);

  logic [OUT_N-1:0] set_hot;
  logic [OUT_N-1:0] clr_hot;
  logic [OUT_N-1:0] full_vec;
  logic [OUT_N-1:0] uf_vec;

  decoder_onehot #(.IN_W(IN_W)) u_set_dec (.idx(set_idx), .onehot(set_hot));
  decoder_onehot #(.IN_W(IN_W)) u_clr_dec (.idx(clr_idx), .onehot(clr_hot));

  // Readiness comes only from stored counts, so clears never gate sets.
  assign set_ready = ~full_vec[set_idx];
  assign rs_busy   = busy_vec[rs_idx];
  assign rt_busy   = busy_vec[rt_idx];

  for (genvar i = 0; i < OUT_N; i++) begin : g_entry
    if (ZERO_LOCK && i == 0) begin : g_lock
      logic unused_hot;
      assign unused_hot  = set_hot[i] ^ clr_hot[i];
      assign busy_vec[i] = 1'b0;
      assign full_vec[i] = 1'b0;
      assign uf_vec[i]   = 1'b0;
    end else begin : g_cnt
      logic [CNT_W-1:0] cnt;
      cnt_op_e          op;
      logic             set_acc;
      logic             clr_req;

      assign set_acc = set_valid & set_ready & set_hot[i];
      assign clr_req = clr_valid & clr_hot[i];

      // A matched set+clear cancels; an accepted set implies cnt < max.
      always_comb begin
        op = CNT_HOLD;
        if (reset || flush)                            op = CNT_ZERO;
        else if (set_acc && !clr_req)                  op = CNT_INC;
        else if (clr_req && !set_acc && cnt != '0)     op = CNT_DEC;
      end

      always_ff @(posedge clk) begin
        unique case (op)
          CNT_ZERO: cnt <= '0;
          CNT_INC:  cnt <= cnt + 1'b1;
          CNT_DEC:  cnt <= cnt - 1'b1;
          default:  cnt <= cnt;
        endcase
      end

      assign uf_vec[i]   = ~flush & clr_req & ~set_acc & (cnt == '0);
      assign busy_vec[i] = |cnt;
      assign full_vec[i] = &cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        err_underflow <= 1'b0;
    else if (|uf_vec) err_underflow <= 1'b1;
  end

endmodule
